hbox_filter: RTL

Parametrised horizontal box (moving-average) filter for the vision pipeline; sits between pixel unpack and the colour-detect stage.
Averages the current pixel with the previous TAPS-1 valid pixels of the same line, per channel (R, G, B).
Uses a running-sum accumulator, adds a runtime bypass and an output-valid strobe, and restarts cleanly at every line start.

---
 rtl/hbox_filter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hbox_filter.sv
// Horizontal box filter: per-channel moving average over the last TAPS pixels of a
// line using a running sum, with bypass, control-packet pass-through and 1-cycle latency.

module hbox_lane #(
  parameter int TAPS = 3,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pix_i,
  input  logic          ctrl_i,
  input  logic          vid_px_i,
  input  logic          line_start_i,
  input  logic          old_en_i,
  input  logic          filt_i,
  input  logic          win_ok_i,
  output logic [DW-1:0] pix_o
);
  localparam int SW = DW + $clog2(TAPS);
  localparam int HN = TAPS - 1;
  localparam logic [SW-1:0] TAPS_W = SW'(TAPS);
  localparam logic [SW-1:0] RECIP  = SW'((1 << SW) / TAPS);

  // sum_q always equals the sum of the history entries; the window adds the current pixel
  logic [HN-1:0][DW-1:0] hist_q, hist_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [DW-1:0]         out_q, out_d;
  logic [SW-1:0]         pix_w, oldest, win;
  logic [2*SW-1:0]       prod;
  logic [SW-1:0]         q0, qt, rem, quo;
  logic                  lane_unused;

  assign pix_w  = SW'(pix_i);
  assign oldest = old_en_i ? SW'(hist_q[HN-1]) : '0;
  assign win    = line_start_i ? pix_w : sum_q + pix_w;

  // Reciprocal estimate is at most one low for win < 2^SW; one remainder check fixes it
  assign prod = {{SW{1'b0}}, win} * {{SW{1'b0}}, RECIP};
  assign q0   = prod[2*SW-1:SW];
  assign qt   = q0 * TAPS_W;
  assign rem  = win - qt;
  assign quo  = (rem >= TAPS_W) ? q0 + SW'(1) : q0;
  assign lane_unused = ^{prod[SW-1:0], quo[SW-1:DW]};

  always_comb begin
    sum_d  = sum_q;
    hist_d = hist_q;
    out_d  = out_q;
    if (ctrl_i) begin
      out_d = pix_i;
    end else if (vid_px_i) begin
      sum_d     = line_start_i ? pix_w : sum_q + pix_w - oldest;
      hist_d[0] = pix_i;
      for (int i = 1; i < HN; i++) hist_d[i] = line_start_i ? '0 : hist_q[i-1];
      if (!filt_i)        out_d = pix_i;
      else if (!win_ok_i) out_d = '0;
      else                out_d = quo[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      sum_q  <= '0;
      out_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      out_q  <= out_d;
    end
  end

  assign pix_o = out_q;
endmodule

module hbox_filter #(
  parameter int TAPS = 3,
  parameter int DW   = 8,
  parameter int XW   = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          packet_video,
  input  logic          enable,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic [XW-1:0] x_in,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          out_valid
);
  localparam int NCH = 3;
  localparam int FW  = $clog2(TAPS);
  localparam logic [FW-1:0] FILL_MAX = FW'(TAPS - 1);
  localparam logic [XW-1:0] X_FULL   = XW'(TAPS - 1);

  logic [FW-1:0]              fill_q, fill_d;
  logic                       out_valid_q;
  logic                       vid_px, line_start, old_en, win_ok;
  logic [NCH-1:0][DW-1:0]     pix_in, pix_out;

  assign vid_px     = packet_video & valid;
  assign line_start = (x_in == '0);
  assign old_en     = (fill_q == FILL_MAX);
  assign win_ok     = (x_in >= X_FULL);
  assign pix_in     = {r_in, g_in, b_in};

  always_comb begin
    fill_d = fill_q;
    if (vid_px) begin
      if (line_start)    fill_d = FW'(1);
      else if (!old_en)  fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= valid;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    hbox_lane #(.TAPS(TAPS), .DW(DW)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .pix_i        (pix_in[c]),
      .ctrl_i       (~packet_video),
      .vid_px_i     (vid_px),
      .line_start_i (line_start),
      .old_en_i     (old_en),
      .filt_i       (enable),
      .win_ok_i     (win_ok),
      .pix_o        (pix_out[c])
    );
  end

  assign r_out     = pix_out[2];
  assign g_out     = pix_out[1];
  assign b_out     = pix_out[0];
  assign out_valid = out_valid_q;
endmodule
